// File: rtl/rf_write_sched_if.sv
// Register-file write-port bundle: core writeback, aux requester and the
// single write port toward Register_File.
interface rf_write_sched_if #(
  parameter int unsigned XLEN = 32
);
  logic            clr_req;
  logic            wb_en;
  logic [4:0]      wb_sel;
  logic [XLEN-1:0] wb_dat;
  logic            aux_valid;
  logic [4:0]      aux_sel;
  logic [XLEN-1:0] aux_dat;
  logic            aux_ready;
  logic [4:0]      RDSel;
  logic [XLEN-1:0] RDDat;
  logic            wen;
  logic            core_stall;
  logic            init_busy;

  modport master (
    output clr_req, wb_en, wb_sel, wb_dat, aux_valid, aux_sel, aux_dat,
    input  aux_ready, RDSel, RDDat, wen, core_stall, init_busy
  );

  modport slave (
    input  clr_req, wb_en, wb_sel, wb_dat, aux_valid, aux_sel, aux_dat,
    output aux_ready, RDSel, RDDat, wen, core_stall, init_busy
  );
endinterface

// File: rtl/rf_write_sched.sv
// Register-file write-port scheduler: post-reset clear of x1..x31, then
// core-priority arbitration with an aux requester and starvation relief.
module rf_write_sched #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned NREG       = 32,
  parameter int unsigned STARVE_LIM = 4
) (
  input logic             Clk,
  input logic             Rst,
  rf_write_sched_if.slave bus
);
  localparam int unsigned SelW = 5;
  localparam int unsigned StW  = $clog2(STARVE_LIM + 1);
  localparam logic [SelW-1:0] LastIdx   = SelW'(NREG - 1);
  localparam logic [StW-1:0]  StarveMax = StW'(STARVE_LIM);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e            state_q;
  logic [SelW-1:0]   idx_q;
  logic [StW-1:0]    starve_q;

  logic core_grant;
  logic aux_grant;
  logic forced;

  always_comb begin
    core_grant = 1'b0;
    aux_grant  = 1'b0;
    forced     = 1'b0;
    if (state_q == StRun && !bus.clr_req) begin
      if (starve_q == StarveMax && bus.aux_valid) begin
        aux_grant = 1'b1;
        forced    = 1'b1;
      end else if (bus.wb_en && bus.wb_sel != '0) begin
        core_grant = 1'b1;
      end else if (bus.aux_valid) begin
        aux_grant = 1'b1;
      end
    end
  end

  // Rst gates the outputs directly so they take reset values the moment it falls.
  always_comb begin
    bus.wen        = 1'b0;
    bus.RDSel      = '0;
    bus.RDDat      = '0;
    bus.aux_ready  = 1'b0;
    bus.core_stall = 1'b0;
    bus.init_busy  = 1'b0;
    if (!Rst) begin
      bus.core_stall = 1'b1;
      bus.init_busy  = 1'b1;
    end else if (state_q == StInit) begin
      bus.wen        = 1'b1;
      bus.RDSel      = idx_q;
      bus.core_stall = 1'b1;
      bus.init_busy  = 1'b1;
    end else begin
      bus.core_stall = forced;
      if (core_grant) begin
        bus.wen   = 1'b1;
        bus.RDSel = bus.wb_sel;
        bus.RDDat = bus.wb_dat;
      end else if (aux_grant) begin
        bus.aux_ready = 1'b1;
        // Aux writes to x0 are acknowledged but dropped.
        if (bus.aux_sel != '0) begin
          bus.wen   = 1'b1;
          bus.RDSel = bus.aux_sel;
          bus.RDDat = bus.aux_dat;
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q  <= StInit;
      idx_q    <= SelW'(1);
      starve_q <= '0;
    end else begin
      case (state_q)
        StInit: begin
          starve_q <= '0;
          if (bus.clr_req) begin
            idx_q <= SelW'(1);
          end else if (idx_q == LastIdx) begin
            state_q <= StRun;
            idx_q   <= SelW'(1);
          end else begin
            idx_q <= idx_q + SelW'(1);
          end
        end
        StRun: begin
          if (bus.clr_req) begin
            state_q  <= StInit;
            idx_q    <= SelW'(1);
            starve_q <= '0;
          end else if (bus.aux_valid && !aux_grant) begin
            if (starve_q != StarveMax) starve_q <= starve_q + StW'(1);
          end else begin
            starve_q <= '0;
          end
        end
        default: state_q <= StInit;
      endcase
    end
  end
endmodule

// File: tb/tb_rf_write_sched.sv
// Self-checking bench for rf_write_sched: directed vectors, multi-cycle corner
// sequences and randomized traffic against a behavioural write-port model.
module tb_rf_write_sched;
  localparam int Lim = 4;

  logic Clk;
  logic Rst;
  rf_write_sched_if #(.XLEN(32)) bus ();

  rf_write_sched #(.XLEN(32), .NREG(32), .STARVE_LIM(Lim)) dut (
    .Clk(Clk),
    .Rst(Rst),
    .bus(bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state
  bit m_init;
  int m_idx;
  int m_wait;
  bit e_wen, e_ready, e_stall, e_busy;
  logic [4:0]  e_sel;
  logic [31:0] e_dat;
  logic [31:0] dut_rf [32];
  logic [31:0] mod_rf [32];

  typedef struct {
    bit          wb_en;
    logic [4:0]  wb_sel;
    logic [31:0] wb_dat;
    bit          aux_valid;
    logic [4:0]  aux_sel;
    logic [31:0] aux_dat;
    bit          x_wen;
    logic [4:0]  x_sel;
    logic [31:0] x_dat;
    bit          x_ready;
    bit          x_stall;
  } vec_t;
  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    m_init = 1'b1;
    m_idx  = 1;
    m_wait = 0;
  endtask

  task automatic model_eval();
    bit core_ok;
    e_wen = 0; e_sel = '0; e_dat = '0; e_ready = 0; e_stall = 0; e_busy = 0;
    core_ok = bus.wb_en && (bus.wb_sel != 0);
    if (m_init) begin
      e_wen = 1; e_sel = 5'(m_idx); e_stall = 1; e_busy = 1;
    end else if (!bus.clr_req) begin
      if (bus.aux_valid && (m_wait >= Lim || !core_ok)) begin
        e_ready = 1;
        e_stall = (m_wait >= Lim);
        if (bus.aux_sel != 0) begin
          e_wen = 1; e_sel = bus.aux_sel; e_dat = bus.aux_dat;
        end
      end else if (core_ok) begin
        e_wen = 1; e_sel = bus.wb_sel; e_dat = bus.wb_dat;
      end
    end
  endtask

  task automatic model_update();
    if (m_init) begin
      m_wait = 0;
      if (bus.clr_req) m_idx = 1;
      else if (m_idx == 31) begin m_init = 0; m_idx = 1; end
      else m_idx++;
    end else if (bus.clr_req) begin
      model_reset();
    end else if (bus.aux_valid && !e_ready) begin
      m_wait = (m_wait + 1 > Lim) ? Lim : m_wait + 1;
    end else begin
      m_wait = 0;
    end
  endtask

  task automatic sample(input bit use_model);
    @(negedge Clk);
    model_eval();
    if (use_model) begin
      chk("rnd_wen",   32'(bus.wen),        32'(e_wen));
      chk("rnd_sel",   32'(bus.RDSel),      32'(e_sel));
      chk("rnd_dat",   bus.RDDat,           e_dat);
      chk("rnd_ready", 32'(bus.aux_ready),  32'(e_ready));
      chk("rnd_stall", 32'(bus.core_stall), 32'(e_stall));
      chk("rnd_busy",  32'(bus.init_busy),  32'(e_busy));
    end
    if (bus.wen === 1'b1) dut_rf[bus.RDSel] = bus.RDDat;
    if (e_wen) mod_rf[e_sel] = e_dat;
  endtask

  task automatic advance();
    @(posedge Clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    bus.clr_req = 0; bus.wb_en = 0; bus.wb_sel = '0; bus.wb_dat = '0;
    bus.aux_valid = 0; bus.aux_sel = '0; bus.aux_dat = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_wen"},   32'(bus.wen),        32'd0);
    chk({tag, "_ready"}, 32'(bus.aux_ready),  32'd0);
    chk({tag, "_stall"}, 32'(bus.core_stall), 32'd1);
    chk({tag, "_busy"},  32'(bus.init_busy),  32'd1);
    chk({tag, "_sel"},   32'(bus.RDSel),      32'd0);
    chk({tag, "_dat"},   bus.RDDat,           32'd0);
  endtask

  task automatic check_clear_run(input string tag);
    for (int i = 1; i <= 31; i++) begin
      sample(0);
      chk({tag, "_wen"},   32'(bus.wen),        32'd1);
      chk({tag, "_sel"},   32'(bus.RDSel),      32'(i));
      chk({tag, "_dat"},   bus.RDDat,           32'd0);
      chk({tag, "_stall"}, 32'(bus.core_stall), 32'd1);
      chk({tag, "_busy"},  32'(bus.init_busy),  32'd1);
      chk({tag, "_ready"}, 32'(bus.aux_ready),  32'd0);
      advance();
    end
  endtask

  initial begin
    vecs[0] = '{1, 5'd2, 32'hFFFFFFCF, 0, 5'd0, 32'h0,        1, 5'd2, 32'hFFFFFFCF, 0, 0};
    vecs[1] = '{1, 5'd0, 32'hFFFCFFFC, 1, 5'd5, 32'h12345678, 1, 5'd5, 32'h12345678, 1, 0};
    vecs[2] = '{0, 5'd0, 32'h0,        1, 5'd0, 32'hDEADBEEF, 0, 5'd0, 32'h0,        1, 0};
    vecs[3] = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 0};
    vecs[4] = '{1, 5'd3, 32'h0000AAAA, 1, 5'd7, 32'h0000BBBB, 1, 5'd3, 32'h0000AAAA, 0, 0};
    vecs[5] = '{0, 5'd3, 32'h0000AAAA, 1, 5'd7, 32'h0000BBBB, 1, 5'd7, 32'h0000BBBB, 1, 0};
    vecs[6] = '{0, 5'd9, 32'h01010101, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 0};

    for (int i = 0; i < 32; i++) begin dut_rf[i] = 32'hX; mod_rf[i] = 32'hX; end
    dut_rf[0] = '0; mod_rf[0] = '0;
    Rst = 1'b0;
    idle_inputs();
    model_reset();
    #3;
    check_reset_outputs("reset");
    @(posedge Clk); #1;
    Rst = 1'b1;

    check_clear_run("init");
    sample(0);
    chk("init_done_busy",  32'(bus.init_busy),  32'd0);
    chk("init_done_stall", 32'(bus.core_stall), 32'd0);
    chk("init_done_wen",   32'(bus.wen),        32'd0);
    advance();

    foreach (vecs[i]) begin
      bus.wb_en = vecs[i].wb_en; bus.wb_sel = vecs[i].wb_sel; bus.wb_dat = vecs[i].wb_dat;
      bus.aux_valid = vecs[i].aux_valid; bus.aux_sel = vecs[i].aux_sel;
      bus.aux_dat = vecs[i].aux_dat;
      sample(0);
      chk($sformatf("vec%0d_wen", i),   32'(bus.wen),        32'(vecs[i].x_wen));
      chk($sformatf("vec%0d_sel", i),   32'(bus.RDSel),      32'(vecs[i].x_sel));
      chk($sformatf("vec%0d_dat", i),   bus.RDDat,           vecs[i].x_dat);
      chk($sformatf("vec%0d_ready", i), 32'(bus.aux_ready),  32'(vecs[i].x_ready));
      chk($sformatf("vec%0d_stall", i), 32'(bus.core_stall), 32'(vecs[i].x_stall));
      advance();
    end
    idle_inputs();
    chk("rf_x2", dut_rf[2], 32'hFFFFFFCF);
    chk("rf_x5", dut_rf[5], 32'h12345678);
    chk("rf_x0", dut_rf[0], 32'h0);

    // Starvation: core wins Lim cycles, then one forced aux cycle.
    bus.wb_en = 1; bus.wb_sel = 5'd3; bus.wb_dat = 32'h33;
    bus.aux_valid = 1; bus.aux_sel = 5'd7; bus.aux_dat = 32'h77;
    for (int i = 0; i < Lim; i++) begin
      sample(0);
      chk("starve_core_sel",   32'(bus.RDSel),      32'd3);
      chk("starve_core_ready", 32'(bus.aux_ready),  32'd0);
      chk("starve_core_stall", 32'(bus.core_stall), 32'd0);
      advance();
    end
    sample(0);
    chk("starve_force_stall", 32'(bus.core_stall), 32'd1);
    chk("starve_force_ready", 32'(bus.aux_ready),  32'd1);
    chk("starve_force_sel",   32'(bus.RDSel),      32'd7);
    chk("starve_force_dat",   bus.RDDat,           32'h77);
    advance();
    bus.aux_sel = 5'd8;
    sample(0);
    chk("starve_after_sel",   32'(bus.RDSel),      32'd3);
    chk("starve_after_ready", 32'(bus.aux_ready),  32'd0);
    advance();
    idle_inputs();

    // clr_req in RUN with a pending aux request: no ack, full clear re-runs.
    bus.clr_req = 1; bus.aux_valid = 1; bus.aux_sel = 5'd9; bus.aux_dat = 32'h99;
    sample(0);
    chk("clr_ready", 32'(bus.aux_ready), 32'd0);
    chk("clr_wen",   32'(bus.wen),       32'd0);
    advance();
    bus.clr_req = 0;
    check_clear_run("reinit");
    sample(0);
    chk("reinit_aux_ready", 32'(bus.aux_ready), 32'd1);
    chk("reinit_aux_sel",   32'(bus.RDSel),     32'd9);
    advance();
    idle_inputs();

    // Asynchronous reset in the middle of a clear.
    bus.clr_req = 1;
    sample(0);
    advance();
    bus.clr_req = 0;
    for (int i = 1; i <= 9; i++) begin sample(0); advance(); end
    sample(0);
    chk("mid_init_sel", 32'(bus.RDSel), 32'd10);
    #2 Rst = 1'b0;
    #1 check_reset_outputs("async_rst");
    model_reset();
    @(posedge Clk); #1;
    Rst = 1'b1;
    check_clear_run("rst_reinit");

    // Randomized traffic against the model, aux held until accepted.
    for (int c = 0; c < 3000; c++) begin
      bus.clr_req = ($urandom_range(0, 149) == 0);
      bus.wb_en   = ($urandom_range(0, 9) < 8);
      bus.wb_sel  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      bus.wb_dat  = $urandom;
      if (!bus.aux_valid && $urandom_range(0, 1) == 1) begin
        bus.aux_valid = 1;
        bus.aux_sel   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
        bus.aux_dat   = $urandom;
      end
      sample(1);
      advance();
      if (e_ready) bus.aux_valid = 0;
    end
    idle_inputs();
    for (int i = 0; i < 32; i++) chk($sformatf("rf_final_x%0d", i), dut_rf[i], mod_rf[i]);
    chk("rf_final_x0_zero", dut_rf[0], 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
